freq_meter_gate: RTL and testbench
==================================

# freq_meter_gate

Gated frequency meter: counts rising edges of an external pulse signal over a fixed window of `GATE_CYCLES` system clocks, then publishes the count with a one-cycle `valid` strobe. It is the measuring counterpart to the lab frequency dividers. It checks divider outputs such as `clk_new` or `enable` on the board, or any external pulse source, and feeds the count to the seven-segment or LED display logic.

## Interface
- `GATE_CYCLES`, default 50_000_000: gate window length in `clk` cycles (≥ 2).
- `CNT_W`, default 27: width of the edge counter and of `freq_count`.

- `clk`  in  1  system clock; every register updates on its rising edge.
- `reset`  in  1  reset, synchronous, active-low.
- `en`  in  1  measurement enable. Level-sensitive; windows run back-to-back while it is high.
- `sig_in`  in  1  signal under measurement. It may be asynchronous to `clk` when `FREQ_METER_SYNC_EN` is defined.
- `freq_count`  out  CNT_W  rising-edge count of the last completed window; held between windows.
- `valid`  out  1  one-cycle strobe, asserted in the cycle `freq_count` updates.
- `overflow`  out  1  last completed window saturated the counter; held with `freq_count`.
- `busy`  out  1  high while a window is open (state GATE).

## Operation
- States: IDLE, GATE.
  - IDLE → GATE on the first clock edge with `en`=1.
  - GATE → IDLE on an edge with `en`=0, whether the window is complete or aborted.
- Edge detection:
  - `prev` register holds the previous detector input.
  - An edge is detected when the input is 1 and `prev` is 0.
  - The detector runs in every state, so no edge is invented at window start.
- In GATE:
  - `gate_cnt` counts 0 … GATE_CYCLES-1.
  - `edge_cnt` increments by 1 per detected edge, with no wrap. At 2^CNT_W-1 it saturates and sets an internal `sat` flag.
- Window end: the edge where `gate_cnt`==GATE_CYCLES-1.
  - `freq_count` ← `edge_cnt` + (edge detected in that final cycle), saturating.
  - `overflow` ← `sat` (or saturation caused by the final edge).
  - `valid` ← 1.
  - `edge_cnt`, `gate_cnt` and `sat` ← 0.
  - If `en`=1, the next window starts immediately; no cycle is lost between windows.
- `en` falling mid-window:
  - The window is aborted and the partial count is discarded.
  - There is no `valid` pulse, and `freq_count`/`overflow` keep their previous values.
  - State returns to IDLE; `edge_cnt` and `gate_cnt` are cleared.
- `en`=0 in the final window cycle: this also counts as an abort (`en` is checked first).
- An edge still inside the synchronizer at window end is counted in the next window if one opens, and dropped otherwise.
- `reset`=0 (sampled on a clock edge) has priority over everything:
  - state IDLE; `freq_count`=0, `valid`=0, `overflow`=0, `busy`=0.
  - All counters, `sat`, synchronizer and `prev` = 0.

## Timing
- `busy` rises on the edge after the first `en`=1 sample. That edge is window cycle 0.
- A window spans exactly GATE_CYCLES clock edges. `valid` is high in the cycle after the last one.
- With back-to-back windows, `valid` pulses every GATE_CYCLES cycles.
- Edge latency, with `sig_in` first sampled high at edge k:
  - with `FREQ_METER_SYNC_EN`: counted at edge k+2;
  - without it: counted at edge k.
- Maximum countable rate is `clk`/2. Narrower pulses may be missed; this is not an error condition.
- Measured frequency = `freq_count` × f_clk / GATE_CYCLES. The default gives 1 s windows at 50 MHz.

## Configuration
- `FREQ_METER_SYNC_EN` defined:
  - `sig_in` passes through a 2-flop synchronizer (`s1`, `s2`), both reset to 0.
  - The detector uses `s2`.
- `FREQ_METER_SYNC_EN` not defined:
  - The detector uses `sig_in` directly.
  - `sig_in` must be synchronous to `clk` (e.g. a divider output in the same domain).
  - Edge latency is 0 cycles.

## Test plan
- Square-wave count: GATE_CYCLES=100, `sig_in` period 10 clocks, `en`=1 → `valid` every 100 cycles, `freq_count`=10, `overflow`=0.
- Saturation: CNT_W=3, `sig_in` period 2 clocks, GATE_CYCLES=100 → `freq_count`=7, `overflow`=1. Next window with `sig_in`=0 → `freq_count`=0, `overflow`=0.
- Abort: drop `en` at window cycle 50 → no `valid` pulse, `freq_count` unchanged, `busy`=0 on the next edge. Re-raise `en` → full 100-cycle window.
- Final-cycle edge: an edge detected exactly at `gate_cnt`=99 → included in that window's `freq_count`.
- Reset mid-window: `reset`=0 for 1 cycle at window cycle 40 → all outputs 0, IDLE, no `valid`. With `en` held high, the next `valid` comes 100 cycles after `busy` rises.
- Sync latency: toggle `sig_in` once and check the `edge_cnt` increment at k+2 (macro defined) vs k (macro undefined).

Source files
------------

// File: rtl/freq_meter_gate.sv
// Gated frequency meter: counts rising edges of sig_in over GATE_CYCLES clocks and publishes the count.
// Optional macro FREQ_METER_SYNC_EN adds a 2-flop input synchronizer ahead of the edge detector.
module freq_meter_gate #(
    parameter int GATE_CYCLES = 50_000_000,
    parameter int CNT_W       = 27
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             en,
    input  logic             sig_in,
    output logic [CNT_W-1:0] freq_count,
    output logic             valid,
    output logic             overflow,
    output logic             busy
);

    localparam int GW = $clog2(GATE_CYCLES);
    localparam logic [GW-1:0]    GATE_LAST = GW'(GATE_CYCLES - 1);
    localparam logic [CNT_W-1:0] CNT_MAX   = {CNT_W{1'b1}};

    typedef enum logic [0:0] {
        IDLE = 1'b0,
        GATE = 1'b1
    } state_t;

    state_t           state_r, state_nxt_s;
    logic [GW-1:0]    gate_cnt_r, gate_nxt_s;
    logic [CNT_W-1:0] edge_cnt_r, edge_nxt_s;
    logic             sat_r, sat_nxt_s;
    logic [CNT_W-1:0] freq_count_r, fc_nxt_s;
    logic             overflow_r, ovf_nxt_s;
    logic             valid_r, valid_nxt_s;
    logic             prev_r;
    logic             det_in_s;
    logic             edge_s;
    logic [CNT_W-1:0] inc_cnt_s;
    logic             inc_hit_s;

    // Saturating increment; MSB flags that the result sits at the counter ceiling.
    function automatic logic [CNT_W:0] sat_inc(input logic [CNT_W-1:0] cnt, input logic inc);
        logic [CNT_W-1:0] nxt;
        if (inc && (cnt != CNT_MAX)) begin
            nxt = cnt + CNT_W'(1'b1);
        end else begin
            nxt = cnt;
        end
        return {(nxt == CNT_MAX), nxt};
    endfunction

`ifdef FREQ_METER_SYNC_EN
    logic s1_r, s2_r;

    // Two-flop synchronizer for an asynchronous sig_in.
    always_ff @(posedge clk) begin
        if (!reset) begin
            s1_r <= 1'b0;
            s2_r <= 1'b0;
        end else begin
            s1_r <= sig_in;
            s2_r <= s1_r;
        end
    end

    assign det_in_s = s2_r;
`else
    assign det_in_s = sig_in;
`endif

    assign edge_s = det_in_s & ~prev_r;
    assign {inc_hit_s, inc_cnt_s} = sat_inc(edge_cnt_r, edge_s);

    // Next-state and window bookkeeping; en is checked before window completion.
    always_comb begin
        state_nxt_s = state_r;
        gate_nxt_s  = gate_cnt_r;
        edge_nxt_s  = edge_cnt_r;
        sat_nxt_s   = sat_r;
        fc_nxt_s    = freq_count_r;
        ovf_nxt_s   = overflow_r;
        valid_nxt_s = 1'b0;
        case (state_r)
            IDLE: begin
                gate_nxt_s = '0;
                edge_nxt_s = '0;
                sat_nxt_s  = 1'b0;
                if (en) begin
                    state_nxt_s = GATE;
                end else begin
                    state_nxt_s = IDLE;
                end
            end
            GATE: begin
                if (!en) begin
                    state_nxt_s = IDLE;
                    gate_nxt_s  = '0;
                    edge_nxt_s  = '0;
                    sat_nxt_s   = 1'b0;
                end else if (gate_cnt_r == GATE_LAST) begin
                    fc_nxt_s    = inc_cnt_s;
                    ovf_nxt_s   = sat_r | inc_hit_s;
                    valid_nxt_s = 1'b1;
                    gate_nxt_s  = '0;
                    edge_nxt_s  = '0;
                    sat_nxt_s   = 1'b0;
                end else begin
                    gate_nxt_s = gate_cnt_r + GW'(1'b1);
                    edge_nxt_s = inc_cnt_s;
                    sat_nxt_s  = sat_r | inc_hit_s;
                end
            end
            default: begin
                state_nxt_s = IDLE;
                gate_nxt_s  = '0;
                edge_nxt_s  = '0;
                sat_nxt_s   = 1'b0;
            end
        endcase
    end

    // State, counters, edge-detector history and published results.
    always_ff @(posedge clk) begin
        if (!reset) begin
            state_r      <= IDLE;
            gate_cnt_r   <= '0;
            edge_cnt_r   <= '0;
            sat_r        <= 1'b0;
            freq_count_r <= '0;
            overflow_r   <= 1'b0;
            valid_r      <= 1'b0;
            prev_r       <= 1'b0;
        end else begin
            state_r      <= state_nxt_s;
            gate_cnt_r   <= gate_nxt_s;
            edge_cnt_r   <= edge_nxt_s;
            sat_r        <= sat_nxt_s;
            freq_count_r <= fc_nxt_s;
            overflow_r   <= ovf_nxt_s;
            valid_r      <= valid_nxt_s;
            prev_r       <= det_in_s;
        end
    end

    assign freq_count = freq_count_r;
    assign overflow   = overflow_r;
    assign valid      = valid_r;
    assign busy       = (state_r == GATE);

endmodule

// File: tb/tb_freq_meter_gate.sv
// Directed self-checking bench for freq_meter_gate (GATE_CYCLES=100); a CNT_W=3 copy covers saturation.
module tb_freq_meter_gate;

    localparam int GC = 100;
`ifdef FREQ_METER_SYNC_EN
    localparam int LAT = 2;
`else
    localparam int LAT = 0;
`endif
    localparam logic [7:0] SAT_FULL = (LAT == 2) ? 8'd48 : 8'd47;

    logic       clk = 1'b0;
    logic       reset;
    logic       en;
    logic       sig_in;
    logic [7:0] fc;
    logic       vld, ovf, busy;
    logic [2:0] fc3;
    logic       vld3, ovf3, busy3;

    int total = 0;
    int bad   = 0;
    int ph    = 0;

    freq_meter_gate #(.GATE_CYCLES(GC), .CNT_W(8)) u_dut (
        .clk(clk), .reset(reset), .en(en), .sig_in(sig_in),
        .freq_count(fc), .valid(vld), .overflow(ovf), .busy(busy)
    );

    freq_meter_gate #(.GATE_CYCLES(GC), .CNT_W(3)) u_sat (
        .clk(clk), .reset(reset), .en(en), .sig_in(sig_in),
        .freq_count(fc3), .valid(vld3), .overflow(ovf3), .busy(busy3)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Drives one sample of the period-10 square wave, then advances one clock.
    task automatic tick_wave();
        sig_in = ((ph % 10) < 5);
        ph = ph + 1;
        tick();
    endtask

    task automatic do_reset();
        reset = 1'b0; en = 1'b0; sig_in = 1'b0;
        tick();
        reset = 1'b1;
    endtask

    task automatic test_reset();
        reset = 1'b0; en = 1'b1; sig_in = 1'b1;
        tick(); tick();
        total++; if (fc !== 8'd0)   begin bad++; $display("FAIL reset_fc: got %0d expected 0", fc); end
        total++; if (vld !== 1'b0)  begin bad++; $display("FAIL reset_valid: got %b expected 0", vld); end
        total++; if (ovf !== 1'b0)  begin bad++; $display("FAIL reset_ovf: got %b expected 0", ovf); end
        total++; if (busy !== 1'b0) begin bad++; $display("FAIL reset_busy: got %b expected 0", busy); end
        reset = 1'b1; en = 1'b0; sig_in = 1'b0;
        tick();
    endtask

    task automatic test_square();
        int nv;
        logic exp_v;
        nv = 0;
        do_reset();
        en = 1'b1; ph = 0;
        for (int i = 0; i < 310; i++) begin
            tick_wave();
            exp_v = (i >= GC) && ((i % GC) == 0);
            if (i == 0) begin
                total++; if (busy !== 1'b1) begin bad++; $display("FAIL square_busy: got %b expected 1", busy); end
            end
            total++;
            if (vld !== exp_v) begin bad++; $display("FAIL square_valid i=%0d: got %b expected %b", i, vld, exp_v); end
            if (exp_v) begin
                nv++;
                total++; if (fc !== 8'd10) begin bad++; $display("FAIL square_count i=%0d: got %0d expected 10", i, fc); end
                total++; if (ovf !== 1'b0) begin bad++; $display("FAIL square_ovf i=%0d: got %b expected 0", i, ovf); end
            end
        end
        total++; if (nv != 3) begin bad++; $display("FAIL square_npulses: got %0d expected 3", nv); end
        en = 1'b0;
    endtask

    task automatic test_saturation();
        do_reset();
        en = 1'b1;
        for (int i = 0; i <= 200; i++) begin
            sig_in = (i < 95) ? ((i % 2) == 0) : 1'b0;
            tick();
            if (i == 100) begin
                total++; if (vld3 !== 1'b1) begin bad++; $display("FAIL sat_valid: got %b expected 1", vld3); end
                total++; if (fc3 !== 3'd7)  begin bad++; $display("FAIL sat_count: got %0d expected 7", fc3); end
                total++; if (ovf3 !== 1'b1) begin bad++; $display("FAIL sat_ovf: got %b expected 1", ovf3); end
                total++; if (fc !== SAT_FULL) begin bad++; $display("FAIL sat_wide_count: got %0d expected %0d", fc, SAT_FULL); end
                total++; if (ovf !== 1'b0)  begin bad++; $display("FAIL sat_wide_ovf: got %b expected 0", ovf); end
            end
            if (i == 200) begin
                total++; if (vld3 !== 1'b1) begin bad++; $display("FAIL unsat_valid: got %b expected 1", vld3); end
                total++; if (fc3 !== 3'd0)  begin bad++; $display("FAIL unsat_count: got %0d expected 0", fc3); end
                total++; if (ovf3 !== 1'b0) begin bad++; $display("FAIL unsat_ovf: got %b expected 0", ovf3); end
            end
        end
        en = 1'b0;
    endtask

    task automatic test_abort();
        do_reset();
        en = 1'b1; ph = 0;
        for (int i = 0; i <= 150; i++) begin
            tick_wave();
            if (i == 100) begin
                total++; if (fc !== 8'd10) begin bad++; $display("FAIL abort_first_count: got %0d expected 10", fc); end
            end
        end
        en = 1'b0;
        tick_wave();
        total++; if (busy !== 1'b0) begin bad++; $display("FAIL abort_busy: got %b expected 0", busy); end
        for (int i = 0; i < 20; i++) begin
            total++; if (vld !== 1'b0) begin bad++; $display("FAIL abort_no_valid i=%0d: got %b expected 0", i, vld); end
            tick_wave();
        end
        total++; if (fc !== 8'd10) begin bad++; $display("FAIL abort_held_count: got %0d expected 10", fc); end
        en = 1'b1;
        for (int j = 0; j <= GC; j++) begin
            tick_wave();
            if (j == 0) begin
                total++; if (busy !== 1'b1) begin bad++; $display("FAIL abort_rearm_busy: got %b expected 1", busy); end
            end
            total++;
            if (vld !== (j == GC)) begin bad++; $display("FAIL abort_rearm_valid j=%0d: got %b expected %b", j, vld, (j == GC)); end
        end
        total++; if (fc !== 8'd10) begin bad++; $display("FAIL abort_rearm_count: got %0d expected 10", fc); end
        en = 1'b0;
    endtask

    task automatic test_final_edge();
        do_reset();
        en = 1'b1;
        for (int i = 0; i <= 200; i++) begin
            sig_in = (i >= (GC - LAT));
            tick();
            if (i == GC) begin
                total++; if (fc !== 8'd1) begin bad++; $display("FAIL final_edge_count: got %0d expected 1", fc); end
            end
            if (i == 2 * GC) begin
                total++; if (fc !== 8'd0) begin bad++; $display("FAIL final_edge_next: got %0d expected 0", fc); end
            end
        end
        en = 1'b0;
    endtask

    task automatic test_reset_mid();
        do_reset();
        en = 1'b1; ph = 5;
        for (int i = 0; i <= 140; i++) begin
            tick_wave();
            if (i == 100) begin
                total++; if (fc !== 8'd10) begin bad++; $display("FAIL rmid_first_count: got %0d expected 10", fc); end
            end
        end
        reset = 1'b0;
        tick_wave();
        total++; if (fc !== 8'd0)   begin bad++; $display("FAIL rmid_fc: got %0d expected 0", fc); end
        total++; if (vld !== 1'b0)  begin bad++; $display("FAIL rmid_valid: got %b expected 0", vld); end
        total++; if (busy !== 1'b0) begin bad++; $display("FAIL rmid_busy: got %b expected 0", busy); end
        reset = 1'b1;
        for (int j = 0; j <= GC; j++) begin
            tick_wave();
            if (j == 0) begin
                total++; if (busy !== 1'b1) begin bad++; $display("FAIL rmid_rearm_busy: got %b expected 1", busy); end
            end
            total++;
            if (vld !== (j == GC)) begin bad++; $display("FAIL rmid_valid_time j=%0d: got %b expected %b", j, vld, (j == GC)); end
        end
        total++; if (fc !== 8'd10) begin bad++; $display("FAIL rmid_count: got %0d expected 10", fc); end
        en = 1'b0;
    endtask

    task automatic test_latency();
        logic [7:0] exp_e;
        do_reset();
        en = 1'b1; sig_in = 1'b0;
        for (int i = 0; i < 10; i++) tick();
        sig_in = 1'b1;
        for (int m = 0; m < 4; m++) begin
            tick();
            exp_e = (m >= LAT) ? 8'd1 : 8'd0;
            total++;
            if (u_dut.edge_cnt_r !== exp_e) begin
                bad++;
                $display("FAIL latency m=%0d: got %0d expected %0d", m, u_dut.edge_cnt_r, exp_e);
            end
        end
        en = 1'b0; sig_in = 1'b0;
    endtask

    initial begin
        reset = 1'b0; en = 1'b0; sig_in = 1'b0;
        tick();
        test_reset();
        test_square();
        test_saturation();
        test_abort();
        test_final_edge();
        test_reset_mid();
        test_latency();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
